// File: rtl/sramgen_sram_4096x8_arbiter.sv
// Two-port round-robin arbiter in front of a single-port SRAM macro with a 1-cycle read.
// An optional zero-fill sweep runs after reset. Each port has a hold register for read responses.
module sramgen_sram_4096x8_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 12,
  parameter int RAM_DEPTH      = 1 << ADDR_WIDTH,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [DATA_WIDTH-1:0] p0_req_din,
  output logic                  p0_resp_valid,
  input  logic                  p0_resp_ready,
  output logic [DATA_WIDTH-1:0] p0_resp_dout,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [DATA_WIDTH-1:0] p1_req_din,
  output logic                  p1_resp_valid,
  input  logic                  p1_resp_ready,
  output logic [DATA_WIDTH-1:0] p1_resp_dout,
  output logic                  sram_we,
  output logic                  sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  init_done_q, init_done_d;
  logic                  rr_ptr_q, rr_ptr_d;
  logic                  pend_q, pend_d;
  logic                  owner_q, owner_d;

  logic [1:0]            req_valid, req_we, resp_ready;
  logic [ADDR_WIDTH-1:0] req_addr [2];
  logic [DATA_WIDTH-1:0] req_din [2];
  logic [1:0]            pend_n, hold_valid, elig, grant, resp_valid;
  logic [DATA_WIDTH-1:0] resp_dout [2];
  logic                  run, gsel;

  assign req_valid   = {p1_req_valid, p0_req_valid};
  assign req_we      = {p1_req_we, p0_req_we};
  assign resp_ready  = {p1_resp_ready, p0_resp_ready};
  assign req_addr[0] = p0_req_addr;
  assign req_addr[1] = p1_req_addr;
  assign req_din[0]  = p0_req_din;
  assign req_din[1]  = p1_req_din;

  // No grants while reset is held, so every request-side output reads 0.
  assign run = (state_q == ST_RUN) && !rst;

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    logic                  hv_q, hv_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;

    assign pend_n[gi]     = pend_q && (owner_q == 1'(gi));
    assign hold_valid[gi] = hv_q;
    // A read may only issue when the previous response leaves this cycle.
    assign elig[gi] = run && req_valid[gi] &&
                      (req_we[gi] || (!hv_q && !(pend_n[gi] && !resp_ready[gi])));
    assign resp_valid[gi] = pend_n[gi] || hv_q;
    // sram_dout is only looked at when a read is in flight for this port.
    assign resp_dout[gi]  = hv_q ? hold_q : (pend_n[gi] ? sram_dout : '0);

    always_comb begin
      hv_d   = hv_q;
      hold_d = hold_q;
      if (pend_n[gi] && !resp_ready[gi]) begin
        hv_d   = 1'b1;
        hold_d = sram_dout;
      end else if (hv_q && resp_ready[gi]) begin
        hv_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hv_q   <= 1'b0;
        hold_q <= '0;
      end else begin
        hv_q   <= hv_d;
        hold_q <= hold_d;
      end
    end
  end

  assign grant[0] = elig[0] && (!elig[1] || !rr_ptr_q);
  assign grant[1] = elig[1] && (!elig[0] ||  rr_ptr_q);
  assign gsel     = grant[1];

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    init_done_d = init_done_q;
    rr_ptr_d    = rr_ptr_q;
    pend_d      = 1'b0;
    owner_d     = owner_q;
    sram_we     = 1'b0;
    sram_wmask  = 1'b0;
    sram_addr   = req_addr[gsel];
    sram_din    = req_din[gsel];
    case (state_q)
      ST_CLEAR: begin
        sram_we    = !rst;
        sram_wmask = !rst;
        sram_addr  = clr_cnt_q;
        sram_din   = '0;
        clr_cnt_d  = clr_cnt_q + 1'b1;
        if (clr_cnt_q == CLR_LAST) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (|grant) begin
          rr_ptr_d   = !gsel;
          sram_we    = req_we[gsel];
          sram_wmask = req_we[gsel];
          if (!req_we[gsel]) begin
            pend_d  = 1'b1;
            owner_d = gsel;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q   <= '0;
      init_done_q <= !CLEAR_ON_RESET;
      rr_ptr_q    <= 1'b0;
      pend_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      init_done_q <= init_done_d;
      rr_ptr_q    <= rr_ptr_d;
      pend_q      <= pend_d;
      owner_q     <= owner_d;
    end
  end

  assign init_done     = init_done_q;
  assign p0_req_ready  = grant[0];
  assign p1_req_ready  = grant[1];
  assign p0_resp_valid = resp_valid[0];
  assign p1_resp_valid = resp_valid[1];
  assign p0_resp_dout  = resp_dout[0];
  assign p1_resp_dout  = resp_dout[1];

endmodule

// File: tb/tb_sramgen_sram_4096x8_arbiter.sv
// Bench for the two-port SRAM arbiter: a behavioural SRAM macro plus a per-port reference
// model of memory contents and outstanding responses, with directed and random traffic.
module tb_sramgen_sram_4096x8_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_resp_valid, p0_resp_ready;
  logic [11:0] p0_req_addr;
  logic [7:0]  p0_req_din, p0_resp_dout;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_resp_valid, p1_resp_ready;
  logic [11:0] p1_req_addr;
  logic [7:0]  p1_req_din, p1_resp_dout;
  logic        sram_we, sram_wmask;
  logic [11:0] sram_addr;
  logic [7:0]  sram_din, sram_dout;

  int checks = 0;
  int errors = 0;

  sramgen_sram_4096x8_arbiter dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_din(p0_req_din), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_resp_dout(p0_resp_dout),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_din(p1_req_din), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_resp_dout(p1_resp_dout),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Single-port macro: registered read, output undefined on write cycles.
  logic [7:0] sram_mem [4096];
  always @(posedge clk) begin
    if (sram_we && sram_wmask) begin
      sram_mem[sram_addr] <= sram_din;
      sram_dout <= 'x;
    end else begin
      sram_dout <= sram_mem[sram_addr];
    end
  end

  // Reference model: expected memory image and at most one undelivered response per port.
  logic [7:0] m_mem [4096];
  logic [1:0] m_has, m_fresh;
  logic [7:0] m_data [2];
  logic       m_rr;

  logic [1:0] obs_rdy, obs_rv;
  logic [7:0] obs_rd [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4096; i++) m_mem[i] = 8'h00;
    m_has   = 2'b00;
    m_fresh = 2'b00;
    m_rr    = 1'b0;
  endtask

  task automatic idle_inputs();
    p0_req_valid = 0; p0_req_we = 0; p0_req_addr = 0; p0_req_din = 0; p0_resp_ready = 1;
    p1_req_valid = 0; p1_req_we = 0; p1_req_addr = 0; p1_req_din = 0; p1_resp_ready = 1;
  endtask

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input logic v0, input logic w0, input logic [11:0] a0, input logic [7:0] d0,
                      input logic r0, input logic v1, input logic w1, input logic [11:0] a1,
                      input logic [7:0] d1, input logic r1);
    logic [1:0]  vv, ww, rr, el, g;
    logic [11:0] aa [2];
    logic [7:0]  dd [2];
    logic        k;
    vv = {v1, v0}; ww = {w1, w0}; rr = {r1, r0};
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    p0_req_valid = v0; p0_req_we = w0; p0_req_addr = a0; p0_req_din = d0; p0_resp_ready = r0;
    p1_req_valid = v1; p1_req_we = w1; p1_req_addr = a1; p1_req_din = d1; p1_resp_ready = r1;
    #1;
    for (int n = 0; n < 2; n++)
      el[n] = vv[n] && (ww[n] || !m_has[n] || (m_fresh[n] && rr[n]));
    g = el;
    if (el == 2'b11) g = m_rr ? 2'b10 : 2'b01;
    k = g[1];
    obs_rdy   = {p1_req_ready, p0_req_ready};
    obs_rv    = {p1_resp_valid, p0_resp_valid};
    obs_rd[0] = p0_resp_dout;
    obs_rd[1] = p1_resp_dout;
    check("req_ready0", p0_req_ready, g[0]);
    check("req_ready1", p1_req_ready, g[1]);
    check("resp_valid0", p0_resp_valid, m_has[0]);
    check("resp_valid1", p1_resp_valid, m_has[1]);
    if (m_has[0]) check("resp_dout0", p0_resp_dout, m_data[0]);
    if (m_has[1]) check("resp_dout1", p1_resp_dout, m_data[1]);
    check("sram_we", sram_we, (g != 0) && ww[k]);
    check("sram_wmask", sram_wmask, (g != 0) && ww[k]);
    if (g != 0) check("sram_addr", sram_addr, aa[k]);
    if ((g != 0) && ww[k]) check("sram_din", sram_din, dd[k]);
    @(posedge clk);
    for (int n = 0; n < 2; n++) begin
      if (m_has[n] && rr[n]) m_has[n] = 1'b0;
      m_fresh[n] = 1'b0;
    end
    if (g != 0) begin
      m_rr = !k;
      if (ww[k]) begin
        m_mem[aa[k]] = dd[k];
      end else begin
        m_has[k]   = 1'b1;
        m_fresh[k] = 1'b1;
        m_data[k]  = m_mem[aa[k]];
      end
    end
    @(negedge clk);
  endtask

  // Called at the falling edge where rst was just released.
  task automatic run_sweep();
    int sweep_bad;
    sweep_bad = 0;
    p0_req_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      #1;
      if (sram_we !== 1'b1 || sram_wmask !== 1'b1 || sram_addr !== 12'(i) ||
          sram_din !== 8'h00 || init_done !== 1'b0 || p0_req_ready !== 1'b0)
        sweep_bad++;
      if (i == 4095) p0_req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("sweep_cycles_bad", sweep_bad, 0);
    check("init_done_after_sweep", init_done, 1);
    check("idle_after_sweep_we", sram_we, 0);
  endtask

  initial begin
    logic        v0, w0, v1, w1, r0, r1;
    logic [11:0] a0, a1;
    rst = 1'b1;
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_init_done", init_done, 0);
    check("rst_sram_we", sram_we, 0);
    check("rst_resp_valid0", p0_resp_valid, 0);
    check("rst_resp_valid1", p1_resp_valid, 0);
    p0_req_valid = 1'b1;
    #1;
    check("rst_req_ready0", p0_req_ready, 0);
    p0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_sweep();

    // Single port write then read-back.
    step(1, 1, 12'h123, 8'hA5, 1, 0, 0, 0, 0, 1);
    step(1, 0, 12'h123, 8'h00, 1, 0, 0, 0, 0, 1);
    check("single_grant", obs_rdy[0], 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("single_resp_valid", obs_rv[0], 1);
    check("single_resp_dout", obs_rd[0], 8'hA5);

    // Contention with the pointer favouring port 0.
    step(1, 1, 12'h200, 8'h11, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1, 12'h300, 8'h22, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 12'h200, 8'h00, 1, 1, 0, 12'h300, 8'h00, 1);
      check("cont_grant0", obs_rdy[0], (i % 2 == 0));
      check("cont_grant1", obs_rdy[1], (i % 2 == 1));
      if (i > 0) begin
        if (i % 2 == 1) check("cont_dout0", obs_rd[0], 8'h11);
        else            check("cont_dout1", obs_rd[1], 8'h22);
      end
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    // Back-pressure on port 1 while port 0 keeps being served.
    step(0, 0, 0, 0, 1, 1, 1, 12'h07F, 8'h3C, 1);
    step(0, 0, 0, 0, 1, 1, 0, 12'h07F, 8'h00, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 12'h200, 8'h00, 1, 1, 0, 12'h07F, 8'h00, 0);
      check("bp_stall1", obs_rdy[1], 0);
      check("bp_valid1", obs_rv[1], 1);
      check("bp_dout1", obs_rd[1], 8'h3C);
      check("bp_serve0", obs_rdy[0], 1);
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("bp_release_valid", obs_rv[1], 1);
    check("bp_release_dout", obs_rd[1], 8'h3C);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("bp_hold_cleared", obs_rv[1], 0);

    // Write from port 1 while port 0's read is in flight.
    step(1, 1, 12'h010, 8'h5A, 1, 0, 0, 0, 0, 1);
    step(1, 0, 12'h010, 8'h00, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 1, 1, 12'h020, 8'h77, 1);
    check("wdp_valid0", obs_rv[0], 1);
    check("wdp_dout0", obs_rd[0], 8'h5A);
    check("wdp_grant1", obs_rdy[1], 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    check("wdp_no_resp1", obs_rv[1], 0);

    // Random traffic over a small address window with occasional far reads.
    for (int c = 0; c < 3000; c++) begin
      v0 = ($urandom_range(0, 3) != 0); w0 = ($urandom_range(0, 2) == 0);
      v1 = ($urandom_range(0, 3) != 0); w1 = ($urandom_range(0, 2) == 0);
      r0 = ($urandom_range(0, 3) != 0); r1 = ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 7) == 0) ? 12'($urandom_range(0, 4095)) : 12'($urandom_range(0, 31));
      step(v0, w0, a0, 8'($urandom), r0, v1, w1, a1, 8'($urandom), r1);
    end

    // Reset with port 0's hold full and port 1's read in flight.
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step(1, 0, 12'h005, 8'h00, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1, 0, 12'h006, 8'h00, 0);
    #1;
    check("pre_rst_valid0", p0_resp_valid, 1);
    check("pre_rst_valid1", p1_resp_valid, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid0", p0_resp_valid, 0);
    check("mid_rst_valid1", p1_resp_valid, 0);
    check("mid_rst_init_done", init_done, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_sweep();

    // Everything reads back as zero after the second sweep.
    for (int c = 0; c < 300; c++) begin
      a0 = 12'($urandom_range(0, 4095));
      a1 = 12'($urandom_range(0, 4095));
      step(1, 0, a0, 8'h00, 1, 1, 0, a1, 8'h00, ($urandom_range(0, 1) == 1));
    end
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
